// File: rtl/wbq_pkg.sv
// Shared types and defaults for the write-back queue.
package wbq_pkg;
   localparam int WBQ_DEPTH = 4;
   localparam int WBQ_AW    = 5;
   localparam int WBQ_DW    = 32;

   localparam logic [WBQ_AW-1:0] ADDR_ZERO = '0;

   typedef struct packed {
      logic [WBQ_AW-1:0] addr;
      logic [WBQ_DW-1:0] data;
   } wbq_entry_t;
endpackage

// File: rtl/wb_queue_if.sv
// Write request handshake from the write-back sources into the queue.
interface wb_queue_if #(
   parameter int AW = 5,
   parameter int DW = 32
);
   logic          WBQ_in_valid;
   logic          WBQ_in_ready;
   logic [AW-1:0] WBQ_in_addr;
   logic [DW-1:0] WBQ_in_data;

   modport master (
      output WBQ_in_valid,
      output WBQ_in_addr,
      output WBQ_in_data,
      input  WBQ_in_ready
   );

   modport slave (
      input  WBQ_in_valid,
      input  WBQ_in_addr,
      input  WBQ_in_data,
      output WBQ_in_ready
   );
endinterface

// File: rtl/wbq_match.sv
// One read port lookup: newest valid queued entry whose address equals rd_addr.
module wbq_match
   import wbq_pkg::*;
#(
   parameter int DEPTH = WBQ_DEPTH,
   parameter int AW    = WBQ_AW,
   parameter int DW    = WBQ_DW,
   localparam int PW   = $clog2(DEPTH)
) (
   input  logic [AW-1:0]             rd_addr,
   input  logic [DEPTH-1:0][AW-1:0]  ent_addr,
   input  logic [DEPTH-1:0][DW-1:0]  ent_data,
   input  logic [DEPTH-1:0]          ent_valid,
   input  logic [PW-1:0]             tail,
   output logic                      hit,
   output logic [DW-1:0]             fwd_data
);

   logic          found;
   logic [DW-1:0] found_data;
   logic [PW-1:0] idx;

   // Walk backwards from the newest slot so the first match wins.
   always_comb begin
      found      = 1'b0;
      found_data = '0;
      idx        = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = tail - PW'(i + 1);
         if (!found && ent_valid[idx] && (ent_addr[idx] == rd_addr) &&
             (rd_addr != AW'(ADDR_ZERO))) begin
            found      = 1'b1;
            found_data = ent_data[idx];
         end
      end
      hit      = found;
      fwd_data = found_data;
   end

endmodule

// File: rtl/wb_queue.sv
// Write-back queue: in-order buffer of pending register writes with operand forwarding.
module wb_queue
   import wbq_pkg::*;
#(
   parameter int DEPTH = WBQ_DEPTH,
   parameter int AW    = WBQ_AW,
   parameter int DW    = WBQ_DW,
   localparam int PW   = $clog2(DEPTH)
) (
   input  logic           clk,
   input  logic           SYS_reset_n,
   wb_queue_if.slave      in_if,
   input  logic           WBQ_flush,
   input  logic           REG_port_busy,
   output logic           REG_write_1,
   output logic [AW-1:0]  REG_address_wr,
   output logic [DW-1:0]  REG_data_wb_in1,
   input  logic [AW-1:0]  REG_address1,
   input  logic [AW-1:0]  REG_address2,
   output logic           WBQ_hit1,
   output logic           WBQ_hit2,
   output logic [DW-1:0]  WBQ_fwd_data1,
   output logic [DW-1:0]  WBQ_fwd_data2,
   output logic [PW:0]    WBQ_count
);

   logic [DEPTH-1:0][AW-1:0] addr_q, addr_d;
   logic [DEPTH-1:0][DW-1:0] data_q, data_d;
   logic [PW-1:0]            head_q, head_d;
   logic [PW-1:0]            tail_q, tail_d;
   logic [PW:0]              count_q, count_d;

   logic                     not_empty;
   logic                     push;
   logic                     pop;
   logic [DEPTH-1:0]         valid_mask;
   logic [PW-1:0]            offset;

   assign not_empty = (count_q != '0);

   // Ready is held low during reset so the source never sees a phantom accept.
   assign in_if.WBQ_in_ready = SYS_reset_n && (count_q != (PW+1)'(DEPTH)) && !WBQ_flush;

   assign push = in_if.WBQ_in_valid && in_if.WBQ_in_ready &&
                 (in_if.WBQ_in_addr != AW'(ADDR_ZERO));
   assign pop  = REG_write_1;

   assign REG_write_1     = not_empty && !REG_port_busy && !WBQ_flush;
   assign REG_address_wr  = not_empty ? addr_q[head_q] : '0;
   assign REG_data_wb_in1 = not_empty ? data_q[head_q] : '0;
   assign WBQ_count       = count_q;

   always_comb begin
      valid_mask = '0;
      offset     = '0;
      for (int j = 0; j < DEPTH; j++) begin
         offset        = PW'(j) - head_q;
         valid_mask[j] = ({1'b0, offset} < count_q);
      end
   end

   always_comb begin
      addr_d  = addr_q;
      data_d  = data_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (WBQ_flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (push) begin
            addr_d[tail_q] = in_if.WBQ_in_addr;
            data_d[tail_q] = in_if.WBQ_in_data;
            tail_d         = tail_q + 1'b1;
         end
         if (pop) begin
            head_d = head_q + 1'b1;
         end
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge SYS_reset_n) begin
      if (!SYS_reset_n) begin
         addr_q  <= '0;
         data_q  <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         addr_q  <= addr_d;
         data_q  <= data_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   wbq_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_match1 (
      .rd_addr   (REG_address1),
      .ent_addr  (addr_q),
      .ent_data  (data_q),
      .ent_valid (valid_mask),
      .tail      (tail_q),
      .hit       (WBQ_hit1),
      .fwd_data  (WBQ_fwd_data1)
   );

   wbq_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_match2 (
      .rd_addr   (REG_address2),
      .ent_addr  (addr_q),
      .ent_data  (data_q),
      .ent_valid (valid_mask),
      .tail      (tail_q),
      .hit       (WBQ_hit2),
      .fwd_data  (WBQ_fwd_data2)
   );

endmodule
